edge_frame_capture: RTL
=======================

# edge_frame_capture

Synthesizable output-side sink for the edge-detection pipeline `build`. Once armed, it discards the fixed pipeline latency and then stores one full frame from the detector's pixel stream (`sout`, one pixel per clock) into an internal frame buffer. A host then reads the frame back through a simple request/valid port. It replaces file capture at the output end on the ZedBoard.

## Interface
- `bitsize`, 8: pixel width in bits.
- `length`, 65536: pixels per frame (256×256); must be a power of two.
- `latency`, 17: pipeline latency of `build`, in clocks, from the first input pixel to the first valid output pixel.
- `clk`  input  1  sole clock; all logic samples on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse, asserted in the same cycle the upstream source drives the first input pixel.
- `sin`  input  `bitsize`  pixel stream from `build.sout`.
- `busy`  output  1  high while in SKIP or CAPTURE.
- `done`  output  1  high while in DONE (frame stored and readable).
- `rd_req`  input  1  read request; sampled only in DONE.
- `rd_addr`  input  `$clog2(length)`  pixel index to read.
- `rd_valid`  output  1  pulses one cycle after an accepted `rd_req`.
- `rd_data`  output  `bitsize`  pixel at `rd_addr`, valid with `rd_valid`.
- `rd_err`  output  1  pulses one cycle after a `rd_req` made outside DONE.

## Operation
- FSM states: IDLE, SKIP, CAPTURE, DONE.
- IDLE: `start` → SKIP; skip counter loaded with `latency-1`.
- SKIP: counter decrements each clock; the `sin` value is ignored. When the counter is 0 → CAPTURE; write address cleared to 0.
- CAPTURE: `sin` is written to the buffer at the write address each clock, and the address increments. After the write at `length-1`, the address wraps to 0 and the FSM moves → DONE.
- DONE: the buffer is readable. `start` → SKIP (new frame, overwriting the old one); `done` drops.
- `start` in SKIP or CAPTURE is ignored; the frame in progress continues.
- An accepted read (`rd_req` in DONE) returns the buffer word one cycle later with `rd_valid`=1.
- A `rd_req` in any other state returns `rd_err`=1 and `rd_valid`=0 one cycle later. `rd_data` then holds its previous value.
- `rd_req` and `start` in the same DONE cycle: the read is still serviced (it returns old-frame data) and the FSM enters SKIP.
- Reset mid-capture: returns to IDLE. Buffer contents are not cleared and are undefined for readback.
- `latency`=0 is not supported; `latency`=1 goes from SKIP to CAPTURE after one clock.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rd_valid`=0, `rd_err`=0, `rd_data`=0, counters 0.
- `start` is sampled at edge T0, and `sin` captured at edge T0+`latency` is pixel 0. This matches the upstream pipeline alignment, with `start` coincident with input pixel 0.
- Pixel k is written at edge T0+`latency`+k.
- `done` rises after edge T0+`latency`+`length`-1.
- Capture is one pixel per clock with no backpressure. Upstream must never stall.
- Read latency is exactly 1 clock, and one read can be accepted per clock (full throughput).

## Structure
- Shared package `edge_pkg`: the FSM state encoding, plus default constants `BITSIZE`, `IMG_W`/`IMG_H`=256, `LENGTH`, and `PIPE_LATENCY`=17, which `build` also uses.
- Sub-module `frame_ram`: simple dual-port RAM, `length`×`bitsize`, with one synchronous write port and one synchronous read port (1-cycle read). It must map to BRAM: no reset on the array.
- The top level holds the FSM, the skip counter, the write address counter, and read-response registers.

## Test plan
Use `bitsize`=8, `length`=16, `latency`=3 unless noted.
- Basic frame: `start` at T0, `sin` = 0xA0+k at edge T0+3+k → `done` after edge T0+18. Reads of addresses 0..15 return 0xA0..0xAF with `rd_valid` one cycle later.
- Latency discard: drive 0xFF on edges T0..T0+2, then 0x00.. → address 0 reads 0x00. No 0xFF is stored.
- Read outside DONE: `rd_req` during CAPTURE → `rd_err`=1 and `rd_valid`=0 next cycle. The capture is unaffected.
- Back-to-back reads: `rd_req` on 16 consecutive cycles → 16 consecutive `rd_valid` pulses in address order.
- Restart: `start` in DONE together with `rd_req` at address 5 → old value returned. The second frame (0x50+k) then overwrites the buffer, and address 5 reads 0x55. `start` pulses during CAPTURE are ignored.
- Async reset: assert `rst` low between clock edges mid-CAPTURE → `busy`/`done`/`rd_valid`/`rd_err` go to 0 immediately. After release, a full frame captures correctly. Also run once with the default `length`/`latency`.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection pipeline and its output-side frame capture.
// Holds the capture FSM encoding and the default image geometry and pipeline latency.
package edge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int BITSIZE      = 8;
  localparam int IMG_W        = 256;
  localparam int IMG_H        = 256;
  localparam int LENGTH       = IMG_W * IMG_H;
  localparam int PIPE_LATENCY = 17;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one synchronous read port.
// The read port has one clock of latency, and its output register holds while rd_en is low.
module frame_ram #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data
);

  logic [width-1:0] mem [depth];

  // NOTE: the array and its read register are deliberately not reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/edge_frame_capture.sv
// Output-side sink for the edge pipeline: skips the pipeline latency after start, stores
// one frame into frame_ram, then serves host reads through a request/valid port.
module edge_frame_capture
  import edge_pkg::*;
#(
  parameter int bitsize = BITSIZE,
  parameter int length  = LENGTH,
  parameter int latency = PIPE_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [bitsize-1:0]        sin,
  output logic                      busy,
  output logic                      done,
  input  logic                      rd_req,
  input  logic [$clog2(length)-1:0] rd_addr,
  output logic                      rd_valid,
  output logic [bitsize-1:0]        rd_data,
  output logic                      rd_err
);

  localparam int aw = $clog2(length);
  localparam int cw = (latency > 1) ? $clog2(latency) : 1;
  localparam logic [aw-1:0] last_addr = aw'(length - 1);
  localparam logic [cw-1:0] skip_load = cw'(latency - 1);

  state_t           state, state_next;
  logic [cw-1:0]    skip_cnt;
  logic [aw-1:0]    wr_addr;
  logic             load, wr_en, rd_accept, rd_seen;
  logic [bitsize-1:0] ram_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_SKIP;
      ST_SKIP:    if (skip_cnt == '0) state_next = ST_CAPTURE;
      ST_CAPTURE: if (wr_addr == last_addr) state_next = ST_DONE;
      ST_DONE:    if (start) state_next = ST_SKIP;
      default:    state_next = ST_IDLE;
    endcase
  end

  // The last SKIP cycle also writes pixel 0 (address is still 0), so pixel k lands at
  // edge T0+latency+k and CAPTURE covers the remaining addresses 1..length-1.
  always_comb begin
    busy      = (state == ST_SKIP) || (state == ST_CAPTURE);
    done      = (state == ST_DONE);
    load      = start && ((state == ST_IDLE) || (state == ST_DONE));
    wr_en     = (state == ST_CAPTURE) || ((state == ST_SKIP) && (skip_cnt == '0));
    rd_accept = rd_req && (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_cnt <= '0;
      wr_addr  <= '0;
    end else if (load) begin
      skip_cnt <= skip_load;
      wr_addr  <= '0;
    end else begin
      if ((state == ST_SKIP) && (skip_cnt != '0)) skip_cnt <= skip_cnt - 1'b1;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
    end
  end

  // rd_seen masks the unreset RAM output register until the first accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      rd_err   <= rd_req && (state != ST_DONE);
      if (rd_accept) rd_seen <= 1'b1;
    end
  end

  assign rd_data = rd_seen ? ram_q : '0;

  frame_ram #(
    .width (bitsize),
    .depth (length)
  ) u_frame_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (sin),
    .rd_en   (rd_accept),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule
